// File: rtl/rv32i_types.sv
// Shared types for the rv32i branch prediction slice.
//   predictor_state   : 2-bit saturating direction counter state
//   prediction_choice : take / no_take direction reported to fetch
//   next_state()      : counter transition on a resolved branch
//   direction_of()    : direction implied by a counter state
package rv32i_types;

    localparam int BHT_IDX_BITS_DEFAULT = 5;
    localparam int BHT_GHR_BITS_DEFAULT = 5;

    typedef enum logic [1:0] {
        strongly_not_taken = 2'b00,
        not_taken          = 2'b01,
        taken              = 2'b10,
        strongly_taken     = 2'b11
    } predictor_state;

    typedef enum logic {
        no_take = 1'b0,
        take    = 1'b1
    } prediction_choice;

    function automatic prediction_choice direction_of(input predictor_state s);
        return (s == taken || s == strongly_taken) ? take : no_take;
    endfunction

    // A correct outcome always lands in the strong state of the current side.
    // A wrong outcome from a weak state crosses straight to the other weak state.
    function automatic predictor_state next_state(input predictor_state cur,
                                                  input logic correct);
        predictor_state nxt;
        nxt = cur;
        unique case (cur)
            strongly_not_taken: nxt = correct ? strongly_not_taken : not_taken;
            not_taken:          nxt = correct ? strongly_not_taken : taken;
            taken:              nxt = correct ? strongly_taken     : not_taken;
            strongly_taken:     nxt = correct ? strongly_taken     : taken;
            default:            nxt = not_taken;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/branch_history_table_counter.sv
// One 2-bit saturating direction counter of the branch history table.
//   clk        : clock
//   reset      : synchronous, active-high; counter returns to not_taken
//   load       : apply a resolved branch to this entry
//   correct_br : stored direction matched the actual outcome
//   prediction : direction implied by the current counter state
module bht_counter_entry
    import rv32i_types::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             correct_br,
    output prediction_choice prediction
);

    predictor_state state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= not_taken;
        end else if (load) begin
            state <= next_state(state, correct_br);
        end
    end

    assign prediction = direction_of(state);

endmodule

// File: rtl/branch_history_table.sv
// PC-indexed table of 2-bit saturating direction counters.
// Fetch side is combinational: pred_idx from the PC, pred from that entry.
// Resolve side updates exactly the entry named by update_idx (the pred_idx
// that travelled with the branch); no bypass, so a same-cycle read sees the
// pre-update state.
//   clk            : clock
//   reset          : synchronous, active-high; wins over update_valid
//   fetch_pc       : PC in fetch
//   pred           : predicted direction for fetch_pc
//   pred_idx       : table index used for pred
//   update_valid   : a conditional branch resolved this cycle
//   update_idx     : index carried from fetch
//   update_taken   : actual outcome
//   mispredict_cnt : resolved branches whose stored direction was wrong (wraps)
// Optional feature: define BHT_GSHARE_EN to XOR a global history register
// (shifted on every resolved branch) into the read index.
module branch_history_table
    import rv32i_types::*;
#(
    parameter int IDX_BITS = BHT_IDX_BITS_DEFAULT,
    parameter int GHR_BITS = BHT_GHR_BITS_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         fetch_pc,
    output prediction_choice    pred,
    output logic [IDX_BITS-1:0] pred_idx,
    input  logic                update_valid,
    input  logic [IDX_BITS-1:0] update_idx,
    input  logic                update_taken,
    output logic [31:0]         mispredict_cnt
);

    localparam int NUM_ENTRIES = 1 << IDX_BITS;

    prediction_choice    entry_pred [NUM_ENTRIES];
    logic [IDX_BITS-1:0] pc_idx;
    logic                correct_br;
    logic                unused_pc_bits;

    assign pc_idx         = fetch_pc[IDX_BITS+1:2];
    assign unused_pc_bits = ^{fetch_pc[31:IDX_BITS+2], fetch_pc[1:0]};

`ifdef BHT_GSHARE_EN
    logic [GHR_BITS-1:0] ghr;

    // History advances at resolve time; the update itself uses update_idx as given.
    always_ff @(posedge clk) begin
        if (reset) begin
            ghr <= '0;
        end else if (update_valid) begin
            ghr <= {ghr[GHR_BITS-2:0], update_taken};
        end
    end

    assign pred_idx = pc_idx ^ IDX_BITS'(ghr);
`else
    logic [GHR_BITS-1:0] unused_ghr_bits;

    assign unused_ghr_bits = '0;
    assign pred_idx        = pc_idx;
`endif

    assign pred       = entry_pred[pred_idx];
    assign correct_br = (entry_pred[update_idx] == prediction_choice'(update_taken));

    for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_entry
        bht_counter_entry u_entry (
            .clk        (clk),
            .reset      (reset),
            .load       (update_valid && (update_idx == IDX_BITS'(i))),
            .correct_br (correct_br),
            .prediction (entry_pred[i])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mispredict_cnt <= '0;
        end else if (update_valid && !correct_br) begin
            mispredict_cnt <= mispredict_cnt + 32'd1;
        end
    end

endmodule
